// File: rtl/vcm_i2c_pkg.sv
// Shared types and constants for the VCM I2C target emulator.
package vcm_i2c_pkg;

    // Default 7-bit target address; the wire bytes are 8'h18 (write) and 8'h19 (read).
    localparam logic [6:0] DefaultSlaveAddr7 = 7'h0C;

    // Debug encoding of the state, as presented on ST.
    localparam logic [3:0] StCodeIdle    = 4'h0;
    localparam logic [3:0] StCodeAddr    = 4'h1;
    localparam logic [3:0] StCodeAddrAck = 4'h2;
    localparam logic [3:0] StCodeIgnore  = 4'h3;
    localparam logic [3:0] StCodeWrByte  = 4'h4;
    localparam logic [3:0] StCodeWrAck   = 4'h5;
    localparam logic [3:0] StCodeWrNack  = 4'h6;
    localparam logic [3:0] StCodeRdByte  = 4'h7;
    localparam logic [3:0] StCodeRdAck   = 4'h8;

    typedef enum logic [3:0] {
        StIdle    = StCodeIdle,
        StAddr    = StCodeAddr,
        StAddrAck = StCodeAddrAck,
        StIgnore  = StCodeIgnore,
        StWrByte  = StCodeWrByte,
        StWrAck   = StCodeWrAck,
        StWrNack  = StCodeWrNack,
        StRdByte  = StCodeRdByte,
        StRdAck   = StCodeRdAck
    } vcm_i2c_state_e;

    // True when the upper seven bits of a received address byte select this target.
    function automatic logic addr_match(logic [7:0] addr_byte, logic [6:0] addr7);
        return addr_byte[7:1] == addr7;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, FiltLen-sample glitch filter and edge pulses for one I2C line.
// The filtered value and its edge pulses change on the same clock edge.
module i2c_line_filter #(
    parameter int unsigned FiltLen = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = (FiltLen > 1) ? $clog2(FiltLen) : 1;

    logic [1:0]      sync_q;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    // Count consecutive samples that disagree with the filtered value; flip on the FiltLen-th.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CntW'(FiltLen - 1)) begin
                filt_d = sync_q[1];
                rise_d = sync_q[1];
                fall_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and filter state; an idle bus reads high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign filt_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/vcm_i2c_slave.sv
// I2C target emulating the VCM driver: 2-byte writes into one 16-bit position register,
// 2-byte reads served MSB then LSB. Oversamples SCL/SDA on CLK_50; never stretches SCL.
module vcm_i2c_slave
    import vcm_i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR7 = DefaultSlaveAddr7,
    parameter int unsigned FILT_LEN    = 3,
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        I2C_SCL,
    inout  wire         I2C_SDA,
    output logic [15:0] VCM_DATA,
    output logic        WR_STROBE,
    output logic        BUSY,
    output logic [3:0]  ST
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_filter #(
        .FiltLen (FILT_LEN)
    ) u_scl_filter (
        .clk_i  (CLK_50),
        .rst_ni (RESET_N),
        .line_i (I2C_SCL),
        .filt_o (scl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(
        .FiltLen (FILT_LEN)
    ) u_sda_filter (
        .clk_i  (CLK_50),
        .rst_ni (RESET_N),
        .line_i (I2C_SDA),
        .filt_o (sda),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    // Bus conditions use the post-edge SCL level, so a coincident SCL fall masks them.
    logic start_evt, stop_evt;
    assign start_evt = sda_fall & scl;
    assign stop_evt  = sda_rise & scl;

    vcm_i2c_state_e state_q, state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     byte0_q, byte0_d;
    logic           rw_q, rw_d;
    logic           ptr_q, ptr_d;       // 0: MSB on the wire, 1: LSB on the wire
    logic           nack_q, nack_d;
    logic [15:0]    rd_data_q, rd_data_d;
    logic [15:0]    vcm_data_q, vcm_data_d;
    logic           strobe_q, strobe_d;
    logic           busy_q, busy_d;
    logic           sda_oe_q, sda_oe_d;

    // Next-state and datapath decode; bus conditions preempt all bit-level activity.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        byte0_d    = byte0_q;
        rw_d       = rw_q;
        ptr_d      = ptr_q;
        nack_d     = nack_q;
        rd_data_d  = rd_data_q;
        vcm_data_d = vcm_data_q;
        strobe_d   = 1'b0;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;

        if (start_evt) begin
            // Repeated start drops any half-written data.
            state_d    = StAddr;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = 2'd0;
            sda_oe_d   = 1'b0;
        end else if (stop_evt) begin
            state_d    = StIdle;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = 2'd0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    sda_oe_d = 1'b0;
                end

                StAddr: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (addr_match(shift_q, SLAVE_ADDR7)) begin
                            state_d   = StAddrAck;
                            rw_d      = shift_q[0];
                            rd_data_d = vcm_data_q;
                            busy_d    = 1'b1;
                            sda_oe_d  = 1'b1;
                        end else begin
                            state_d = StIgnore;
                            busy_d  = 1'b0;
                        end
                    end
                end

                StIgnore: begin
                    sda_oe_d = 1'b0;
                end

                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d  = StRdByte;
                            shift_d  = rd_data_q[15:8];
                            ptr_d    = 1'b0;
                            sda_oe_d = ~rd_data_q[15];
                        end else begin
                            state_d    = StWrByte;
                            byte_cnt_d = 2'd0;
                            sda_oe_d   = 1'b0;
                        end
                    end
                end

                StWrByte: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (byte_cnt_q < 2'd2) begin
                            state_d  = StWrAck;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d  = StWrNack;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                StWrAck: begin
                    if (scl_rise) begin
                        if (byte_cnt_q == 2'd0) begin
                            byte0_d = shift_q;
                        end else if (byte_cnt_q == 2'd1) begin
                            vcm_data_d = {byte0_q, shift_q};
                            strobe_d   = 1'b1;
                        end
                    end else if (scl_fall) begin
                        state_d    = StWrByte;
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        sda_oe_d   = 1'b0;
                    end
                end

                StWrNack: begin
                    sda_oe_d = 1'b0;
                    if (scl_fall) begin
                        state_d = StIgnore;
                        busy_d  = 1'b0;
                    end
                end

                StRdByte: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d  = StRdAck;
                            sda_oe_d = 1'b0;
                        end else begin
                            // A 1 bit releases the line, a 0 bit pulls it low.
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end

                StRdAck: begin
                    if (scl_rise) begin
                        nack_d = sda;
                    end else if (scl_fall) begin
                        if (nack_q) begin
                            state_d  = StIdle;
                            busy_d   = 1'b0;
                            sda_oe_d = 1'b0;
                        end else begin
                            state_d   = StRdByte;
                            bit_cnt_d = 4'd0;
                            ptr_d     = ~ptr_q;
                            shift_d   = ptr_q ? rd_data_q[15:8] : rd_data_q[7:0];
                            sda_oe_d  = ptr_q ? ~rd_data_q[15] : ~rd_data_q[7];
                        end
                    end
                end

                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset releases SDA asynchronously.
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            byte_cnt_q <= 2'd0;
            shift_q    <= 8'h00;
            byte0_q    <= 8'h00;
            rw_q       <= 1'b0;
            ptr_q      <= 1'b0;
            nack_q     <= 1'b0;
            rd_data_q  <= 16'h0000;
            vcm_data_q <= RESET_VALUE;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            byte0_q    <= byte0_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            nack_q     <= nack_d;
            rd_data_q  <= rd_data_d;
            vcm_data_q <= vcm_data_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    assign I2C_SDA   = sda_oe_q ? 1'b0 : 1'bz;
    assign VCM_DATA  = vcm_data_q;
    assign WR_STROBE = strobe_q;
    assign BUSY      = busy_q;
    assign ST        = state_q;

endmodule

// File: doc/vcm_i2c_slave.md
Name: vcm_i2c_slave

Overview:
- I2C target (responder) that emulates the VCM driver at the far end of the VCM I2C master. Lets the focus-control chain be looped back on-board and benched without the real actuator.
- Accepts 2-byte register writes and serves 2-byte reads of one 16-bit VCM position register.
- Runs from CLK_50 and oversamples SCL/SDA; it never drives SCL (no clock stretching).

Parameters:
- SLAVE_ADDR7, 7'h0C, 7-bit address; wire bytes are 8'h18 for write and 8'h19 for read.
- FILT_LEN, 3, number of consecutive equal samples needed before a filtered line changes.
- RESET_VALUE, 16'h0000, value VCM_DATA takes on reset.

Ports:
- CLK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  reset, asynchronous, active-low.
- I2C_SCL  in  1  bus clock from the master.
- I2C_SDA  inout  1  open-drain data line; the block only drives 0 or z.
- VCM_DATA  out  16  committed register value {byte0, byte1}.
- WR_STROBE  out  1  one-cycle pulse when VCM_DATA is updated.
- BUSY  out  1  high from an address-matched START until STOP or NACK release.
- ST  out  4  debug copy of the current state.

Behaviour:
- Reset values: VCM_DATA=RESET_VALUE, WR_STROBE=0, BUSY=0, ST=IDLE, SDA released (z), bit and byte counters=0.
  - Reset is asynchronous. Asserting it mid-transfer releases SDA in the same instant.
- Input conditioning, for each line:
  - 2-flop synchronizer, then a FILT_LEN-sample glitch filter.
  - Edge pulses are generated on the filtered value.
  - Latency from pin change to filtered edge is at most 2+FILT_LEN+1 = 6 cycles. This is well inside the 400 kHz low time (≥65 cycles).
- Bus events, taken on filtered signals:
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
  - SDA is sampled on each SCL rise, MSB first.
- Drive rules:
  - SDA changes only on the cycle after a filtered SCL fall.
  - The ACK low is asserted after the fall that ends bit 8 and released after the next fall.
- States:
  - IDLE: SDA z. START -> ADDR, with bitcnt=0.
  - ADDR: shift in 8 bits. After bit 8:
    - address match -> ADDR_ACK, with rw=bit0;
    - mismatch -> IGNORE.
  - IGNORE: SDA z until the next START or STOP.
  - ADDR_ACK: drive 0 for one bit. Then:
    - rw=0 -> WR_BYTE, with bytecnt=0;
    - rw=1 -> RD_BYTE, with shifter=VCM_DATA[15:8].
    - BUSY=1 from entry to ADDR_ACK.
  - WR_BYTE: shift in 8 bits. Then:
    - bytecnt<2 -> WR_ACK;
    - bytecnt≥2 -> WR_NACK.
  - WR_ACK: drive 0 for one bit.
    - bytecnt=0: store byte0.
    - bytecnt=1: VCM_DATA <= {byte0, byte1} and pulse WR_STROBE on the ACK-slot SCL rise.
    - Then bytecnt++ and go to WR_BYTE.
  - WR_NACK: release for one bit, then IGNORE. Extra bytes are discarded.
  - RD_BYTE: drive shifter bits. A 0 bit drives low; a 1 bit releases. Then go to RD_ACK.
  - RD_ACK: SDA z; sample the master's bit on SCL rise.
    - ACK(0) -> RD_BYTE with the next byte. The sequence alternates LSB, MSB, LSB..., wrapping on pointer toggle.
    - NACK(1) -> IDLE, with BUSY=0.
- Boundary cases:
  - STOP in any state -> IDLE, SDA z, BUSY=0. A write with fewer than 2 bytes leaves VCM_DATA unchanged and gives no strobe.
  - START in any state (repeated start) -> ADDR. Any partial write is discarded.
  - Simultaneous SCL/SDA filtered edges: START/STOP detection takes priority over bit sampling.
  - Read data is snapshotted at ADDR_ACK. A strobe that occurs during a read cannot happen, since the bus is owned by one transaction.

Decomposition:
- Package vcm_i2c_pkg holds:
  - state enum (IDLE, ADDR, ADDR_ACK, IGNORE, WR_BYTE, WR_ACK, WR_NACK, RD_BYTE, RD_ACK);
  - default SLAVE_ADDR7;
  - the ST debug encoding.
- Sub-module i2c_line_filter: synchronizer, glitch filter and rise/fall pulses. Instanced twice, once for SCL and once for SDA.

Test Plan:
- Write 0x18, 0x12, 0x34, STOP at 400 kHz:
  - three ACKs seen;
  - VCM_DATA=0x1234;
  - WR_STROBE high exactly 1 cycle.
- After that write, read 0x19; master ACKs byte 1 and NACKs byte 2:
  - bytes 0x12, 0x34 are returned;
  - SDA is released after the NACK;
  - BUSY falls.
- Address 0x30, 0x55, 0x66:
  - NACK on the address;
  - SDA never driven;
  - VCM_DATA unchanged, no strobe.
- Write 0x18, 0xAB, then STOP:
  - VCM_DATA stays 0x1234, no strobe.
- Write 0x18, 0xAB, then a repeated START with 0x19 read:
  - returns 0x12, 0x34.
- 2-cycle glitch on SCL during a data bit:
  - no extra bit is shifted and the data is correct.
- RESET_N low mid-ACK:
  - SDA goes z immediately;
  - VCM_DATA=0x0000, ST=IDLE.
